keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Scan sequencer and event generator for the 4x4 key matrix. It drives the column lines one-hot at a programmable slot rate and samples the row lines after a settle delay. It debounces whole-matrix snapshots over several frames and delivers one key code per debounced press on a valid/ready handshake. It sits between the matrix pins and the application logic and replaces free-running per-clock scanning.

## Interface
- CLK_DIV, 1000: clock cycles per column slot; legal range ≥ SETTLE+1.
- SETTLE, 8: cycle within the slot, counted from 0, at which the synchronized rows are sampled; legal range ≥ 3.
- DEBOUNCE_FRAMES, 4: consecutive identical frames required to accept a press or release; legal range 1..15.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- row_i  in  4  matrix row inputs, active-high, asynchronous to clk.
- col_o  out  4  one-hot column drive.
- key_code  out  4  debounced key code, valid while key_valid=1.
- key_valid  out  1  event pending.
- key_ready  in  1  consumer accepts the event when key_valid & key_ready.
- key_held  out  1  a debounced key is down.
- multi_err  out  1  one-cycle pulse at the end of a frame that saw more than one key.
- key_overrun  out  1  one-cycle pulse when an accepted press is dropped because key_valid is still pending.

## Operation
- row_i passes through a 2-FF synchronizer.
- slot_cnt runs 0..CLK_DIV-1. col_idx advances 0..3 and wraps at slot_cnt=CLK_DIV-1. col_o = 1<<col_idx.
- At slot_cnt=SETTLE, the synchronized rows are written into the 16-bit frame snapshot, bits [4*col_idx +: 4].
- Frame end is slot_cnt=CLK_DIV-1 with col_idx=3. At frame end the snapshot is classified as NONE (0 bits set), SINGLE (1 bit) or MULTI (more than 1 bit). The snapshot then clears.
- Code mapping: column c, row bit r gives code = 4*(3-c)+r. So col_o=1000 with row 0001 is code 0, and col_o=0001 with row 1000 is code 15.
- Debounce FSM, evaluated only at frame end, with cnt and cand registers:
  - RELEASED: SINGLE loads cand=code, cnt=1 and goes to PRESS_PEND. If DEBOUNCE_FRAMES=1 it accepts immediately.
  - PRESS_PEND: SINGLE with the same code increments cnt. A different code reloads cand with cnt=1. NONE or MULTI returns to RELEASED. When cnt reaches DEBOUNCE_FRAMES: accept, go to HELD.
  - HELD: NONE gives cnt=1 and goes to RELEASE_PEND. SINGLE or MULTI stays in HELD; a second key is never reported while one is held.
  - RELEASE_PEND: NONE increments cnt; reaching DEBOUNCE_FRAMES goes to RELEASED. SINGLE or MULTI returns to HELD.
- Accept: if key_valid=0, or key_ready=1 in the same cycle, load key_code=cand and set key_valid=1. Otherwise keep the old code and pulse key_overrun.
- key_held = 1 in HELD and RELEASE_PEND.
- multi_err pulses on every MULTI frame in every state.

## Timing
- Reset values: col_o=0001, key_code=0, key_valid=0, key_held=0, multi_err=0, key_overrun=0. FSM is in RELEASED, all counters 0, snapshot 0.
- Frame period is 4*CLK_DIV cycles.
- Row-to-sample latency is 2 cycles (synchronizer). A row change settled by slot cycle SETTLE-2 is captured.
- key_valid and key_held rise on the cycle after the frame-end edge of the DEBOUNCE_FRAMES-th qualifying frame.
- key_valid drops the cycle after a cycle with key_valid & key_ready, unless a new accept occurs in that same cycle.
- key_code is stable while key_valid=1.
- Reset mid-frame or mid-debounce discards the snapshot and any pending event immediately, asynchronously.

## Structure
- Shared package keypad_pkg holds: KEY_W=4, the state enum {RELEASED, PRESS_PEND, HELD, RELEASE_PEND}, the frame class enum {NONE, SINGLE, MULTI}, and the code-mapping function.
- One sub-module, keypad_frame_scanner, contains the prescaler, column drive, synchronizer, snapshot and classifier. It outputs a frame_done strobe, the class and the code. The FSM and handshake live in the top module.

## Test plan
Sim parameters: CLK_DIV=16, SETTLE=4, DEBOUNCE_FRAMES=3.
- Reset, then idle 256 cycles: outputs equal their reset values; col_o cycles 0001→0010→0100→1000, 16 cycles each.
- row_i=0001 whenever col_o=1000, for 5 frames, key_ready=1: key_code=0 and key_valid high for exactly 1 cycle, the cycle after frame 3 ends; key_held stays 1 until 3 empty frames have passed.
- Key 5 present on alternating frames: no key_valid and no key_held.
- Keys 5 and 6 together for 4 frames: 4 multi_err pulses, no event.
- key_ready=0; press 9 then release; press 12: key_code stays 9 and key_overrun pulses once. Raising key_ready then completes the handshake for code 9 only.
- rst_n low while HELD on key 3: outputs reset immediately and col_o=0001. Releasing the key produces no event.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        HELD,
        RELEASE_PEND
    } kstate_t;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } fclass_t;

    // Column c, row r -> code 4*(3-c)+r (rightmost driven column gives the high codes)
    function automatic logic [KEY_W-1:0] key_code_of(input logic [1:0] col, input logic [1:0] row);
        return KEY_W'(4 * (3 - int'(col)) + int'(row));
    endfunction

endpackage

// File: rtl/keypad_frame_scanner.sv
// Column prescaler, row synchronizer, frame snapshot and per-frame classifier.
module keypad_frame_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV = 1000,
    parameter int SETTLE  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       row_i,
    output logic [3:0]       col_o,
    output logic             frame_done,
    output fclass_t          frame_class,
    output logic [KEY_W-1:0] frame_code
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(SETTLE);

    logic [3:0]       row_meta, row_sync;
    logic [CNT_W-1:0] slot_cnt;
    logic [1:0]       col_idx;
    logic [15:0]      snap;
    logic             slot_end;
    logic [4:0]       ones;
    logic [3:0]       hit;

    assign slot_end   = (slot_cnt == SLOT_LAST);
    assign frame_done = slot_end && (col_idx == 2'd3);
    assign col_o      = 4'b0001 << col_idx;

    // Two-stage synchronizer for the asynchronous row lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= '0;
            row_sync <= '0;
        end else begin
            row_meta <= row_i;
            row_sync <= row_meta;
        end
    end

    // Slot prescaler and column index, column advances on the last slot cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            col_idx  <= '0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Snapshot: one nibble per column at the settle point, cleared as the frame is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap <= '0;
        end else if (frame_done) begin
            snap <= '0;
        end else if (slot_cnt == SAMPLE_AT) begin
            snap[{col_idx, 2'b00} +: 4] <= row_sync;
        end
    end

    // Count set bits and remember the last one; the code only matters for SINGLE frames
    always_comb begin
        ones = '0;
        hit  = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap[i]) begin
                ones = ones + 5'd1;
                hit  = 4'(i);
            end
        end
        frame_class = NONE;
        if (ones == 5'd1)
            frame_class = SINGLE;
        else if (ones > 5'd1)
            frame_class = MULTI;
        frame_code = key_code_of(hit[3:2], hit[1:0]);
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan controller: frame debounce FSM and key event handshake.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int CLK_DIV         = 1000,
    parameter int SETTLE          = 8,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       row_i,
    output logic [3:0]       col_o,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_held,
    output logic             multi_err,
    output logic             key_overrun
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE_FRAMES);

    logic             frame_done;
    fclass_t          frame_class;
    logic [KEY_W-1:0] frame_code;

    kstate_t          state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic [KEY_W-1:0] cand, cand_nx;
    logic             accept;

    keypad_frame_scanner #(
        .CLK_DIV (CLK_DIV),
        .SETTLE  (SETTLE)
    ) u_scanner (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_i       (row_i),
        .col_o       (col_o),
        .frame_done  (frame_done),
        .frame_class (frame_class),
        .frame_code  (frame_code)
    );

    // Debounce state, frame counter and candidate code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RELEASED;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            cand  <= cand_nx;
        end
    end

    // Debounce transitions, evaluated only on the frame-end strobe
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cand_nx  = cand;
        accept   = 1'b0;
        if (frame_done) begin
            case (state)
                RELEASED: begin
                    if (frame_class == SINGLE) begin
                        cand_nx = frame_code;
                        cnt_nx  = 4'd1;
                        if (DEB == 4'd1) begin
                            accept   = 1'b1;
                            state_nx = HELD;
                        end else begin
                            state_nx = PRESS_PEND;
                        end
                    end
                end
                PRESS_PEND: begin
                    if (frame_class == SINGLE) begin
                        if (frame_code == cand) begin
                            cnt_nx = cnt + 4'd1;
                            if (cnt_nx == DEB) begin
                                accept   = 1'b1;
                                state_nx = HELD;
                            end
                        end else begin
                            cand_nx = frame_code;
                            cnt_nx  = 4'd1;
                        end
                    end else begin
                        state_nx = RELEASED;
                        cnt_nx   = '0;
                    end
                end
                HELD: begin
                    // Further keys while one is held are ignored
                    if (frame_class == NONE) begin
                        cnt_nx   = (DEB == 4'd1) ? 4'd0 : 4'd1;
                        state_nx = (DEB == 4'd1) ? RELEASED : RELEASE_PEND;
                    end
                end
                RELEASE_PEND: begin
                    if (frame_class == NONE) begin
                        cnt_nx = cnt + 4'd1;
                        if (cnt_nx == DEB) begin
                            state_nx = RELEASED;
                            cnt_nx   = '0;
                        end
                    end else begin
                        state_nx = HELD;
                    end
                end
                default: state_nx = RELEASED;
            endcase
        end
    end

    // Held indication straight from the debounce state
    always_comb begin
        key_held = (state == HELD) || (state == RELEASE_PEND);
    end

    // Event register: accept loads unless a pending code would be overwritten
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_overrun <= 1'b0;
            multi_err   <= 1'b0;
        end else begin
            multi_err   <= frame_done && (frame_class == MULTI);
            key_overrun <= 1'b0;
            if (accept && (!key_valid || key_ready)) begin
                key_code  <= cand_nx;
                key_valid <= 1'b1;
            end else begin
                if (accept)
                    key_overrun <= 1'b1;
                if (key_valid && key_ready)
                    key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: frame-level key matrix model and debounce reference.
module tb_keypad_scan_ctrl;

    localparam int CLK_DIV = 16;
    localparam int SETTLE  = 4;
    localparam int DEB     = 3;
    localparam int FRAME   = 4 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic       key_held;
    logic       multi_err;
    logic       key_overrun;

    // Pressed keys indexed by key code
    logic [15:0] keys = '0;

    int checks = 0;
    int errors = 0;

    // Reference: frame-history view of the debounce rules
    bit         m_held;
    int         run_len, none_len;
    logic [3:0] run_code;
    bit         m_valid;
    logic [3:0] m_code;

    // Observed scenario counters
    int         obs_hs, obs_ovr, obs_multi, obs_held;
    logic [3:0] hs_code;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .CLK_DIV         (CLK_DIV),
        .SETTLE          (SETTLE),
        .DEBOUNCE_FRAMES (DEB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_i       (row_i),
        .col_o       (col_o),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_held    (key_held),
        .multi_err   (multi_err),
        .key_overrun (key_overrun)
    );

    // Key matrix: a driven column c shows row r high when code 4*(3-c)+r is pressed
    always_comb begin
        row_i = '0;
        for (int c = 0; c < 4; c++)
            if (col_o[c])
                for (int r = 0; r < 4; r++)
                    row_i[r] = row_i[r] | keys[4 * (3 - c) + r];
    end

    task automatic model_reset();
        m_held = 0; run_len = 0; none_len = 0; run_code = '0;
        m_valid = 0; m_code = '0;
    endtask

    task automatic clear_obs();
        obs_hs = 0; obs_ovr = 0; obs_multi = 0; obs_held = 0; hs_code = '0;
    endtask

    // One full frame with a fixed key set and ready level, checked every cycle
    task automatic drive_frame(input logic [15:0] k, input logic rdy);
        int n;
        bit do_acc, new_held, mul, ovr;
        logic [3:0] c, exp_col;
        keys = k;
        key_ready = rdy;
        n = $countones(k);
        mul = (n > 1);
        c = '0;
        for (int b = 0; b < 16; b++) if (k[b]) c = 4'(b);
        if (n == 1) begin
            run_len = (run_len > 0 && run_code == c) ? run_len + 1 : 1;
            run_code = c;
        end else begin
            run_len = 0;
        end
        none_len = (n == 0) ? none_len + 1 : 0;
        do_acc = 0; new_held = m_held; ovr = 0;
        if (!m_held) begin
            if (run_len == DEB) begin do_acc = 1; new_held = 1; end
        end else if (none_len == DEB) begin
            new_held = 0;
        end
        for (int j = 0; j < FRAME; j++) begin
            if (key_valid && key_ready) begin obs_hs++; hs_code = key_code; end
            @(posedge clk); #1;
            if (j == FRAME - 1 && do_acc) begin
                if (!m_valid || rdy) begin m_valid = 1; m_code = run_code; end
                else ovr = 1;
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
            if (j == FRAME - 1) m_held = new_held;
            exp_col = 4'b0001 << (((j + 1) / CLK_DIV) % 4);
            checks += 6;
            if (col_o !== exp_col) begin errors++; $display("FAIL col_o j=%0d got %b want %b", j, col_o, exp_col); end
            if (key_valid !== m_valid) begin errors++; $display("FAIL key_valid j=%0d got %b want %b", j, key_valid, m_valid); end
            if (key_code !== m_code) begin errors++; $display("FAIL key_code j=%0d got %0d want %0d", j, key_code, m_code); end
            if (key_held !== m_held) begin errors++; $display("FAIL key_held j=%0d got %b want %b", j, key_held, m_held); end
            if (multi_err !== (j == FRAME - 1 && mul)) begin errors++; $display("FAIL multi_err j=%0d got %b", j, multi_err); end
            if (key_overrun !== (j == FRAME - 1 && ovr)) begin errors++; $display("FAIL key_overrun j=%0d got %b", j, key_overrun); end
            if (key_overrun) obs_ovr++;
            if (multi_err) obs_multi++;
            if (key_held) obs_held++;
        end
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) drive_frame(16'h0000, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        #12;
        checks += 6;
        if (col_o !== 4'b0001) begin errors++; $display("FAIL reset_col got %b want 0001", col_o); end
        if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code got %0d want 0", key_code); end
        if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", key_valid); end
        if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got %b want 0", key_held); end
        if (multi_err !== 1'b0) begin errors++; $display("FAIL reset_multi got %b want 0", multi_err); end
        if (key_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", key_overrun); end
        @(posedge clk); #1;
        rst_n = 1;
        clear_obs();
        idle_frames(4);
        checks++;
        if (obs_hs + obs_held + obs_multi + obs_ovr !== 0) begin errors++; $display("FAIL idle_activity got %0d want 0", obs_hs + obs_held + obs_multi + obs_ovr); end
    endtask

    task automatic test_single_press();
        int held_before;
        clear_obs();
        for (int i = 0; i < 5; i++) drive_frame(16'h0001, 1'b1);
        checks += 2;
        if (obs_hs !== 1) begin errors++; $display("FAIL press_handshakes got %0d want 1", obs_hs); end
        if (hs_code !== 4'd0) begin errors++; $display("FAIL press_code got %0d want 0", hs_code); end
        held_before = obs_held;
        idle_frames(2);
        checks++;
        if (key_held !== 1'b1) begin errors++; $display("FAIL held_after_2_empty got %b want 1", key_held); end
        idle_frames(1);
        checks += 2;
        if (key_held !== 1'b0) begin errors++; $display("FAIL held_after_3_empty got %b want 0", key_held); end
        // held from end of frame 3 through end of the 3rd empty frame
        if (obs_held - held_before !== 2 * FRAME + FRAME - 1) begin errors++; $display("FAIL held_cycles got %0d want %0d", obs_held - held_before, 3 * FRAME - 1); end
    endtask

    task automatic test_alternating();
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            drive_frame(16'h0020, 1'b1);
            drive_frame(16'h0000, 1'b1);
        end
        checks++;
        if (obs_hs + obs_held !== 0) begin errors++; $display("FAIL alternating got hs=%0d held=%0d want 0", obs_hs, obs_held); end
    endtask

    task automatic test_multi();
        clear_obs();
        for (int i = 0; i < 4; i++) drive_frame(16'h0060, 1'b1);
        idle_frames(1);
        checks += 2;
        if (obs_multi !== 4) begin errors++; $display("FAIL multi_pulses got %0d want 4", obs_multi); end
        if (obs_hs + obs_held !== 0) begin errors++; $display("FAIL multi_event got hs=%0d held=%0d want 0", obs_hs, obs_held); end
    endtask

    task automatic test_overrun();
        clear_obs();
        for (int i = 0; i < 3; i++) drive_frame(16'h0200, 1'b0);
        for (int i = 0; i < 3; i++) drive_frame(16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) drive_frame(16'h1000, 1'b0);
        checks += 2;
        if (obs_ovr !== 1) begin errors++; $display("FAIL overrun_pulses got %0d want 1", obs_ovr); end
        if (key_code !== 4'd9) begin errors++; $display("FAIL overrun_code got %0d want 9", key_code); end
        drive_frame(16'h0000, 1'b1);
        idle_frames(3);
        checks += 2;
        if (obs_hs !== 1) begin errors++; $display("FAIL overrun_handshakes got %0d want 1", obs_hs); end
        if (hs_code !== 4'd9) begin errors++; $display("FAIL overrun_hs_code got %0d want 9", hs_code); end
    endtask

    task automatic test_async_reset();
        clear_obs();
        for (int i = 0; i < 4; i++) drive_frame(16'h0008, 1'b1);
        repeat (20) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        checks += 4;
        if (key_held !== 1'b0) begin errors++; $display("FAIL async_held got %b want 0", key_held); end
        if (col_o !== 4'b0001) begin errors++; $display("FAIL async_col got %b want 0001", col_o); end
        if (key_code !== 4'd0) begin errors++; $display("FAIL async_code got %0d want 0", key_code); end
        if (key_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b want 0", key_valid); end
        keys = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        clear_obs();
        idle_frames(4);
        checks++;
        if (obs_hs + obs_held !== 0) begin errors++; $display("FAIL async_release_event got hs=%0d held=%0d want 0", obs_hs, obs_held); end
    endtask

    task automatic test_random();
        int sel;
        logic [3:0] cur, a, b;
        logic [15:0] k;
        cur = 4'($urandom_range(0, 15));
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if ($urandom_range(0, 5) == 0) cur = 4'($urandom_range(0, 15));
            k = '0;
            if (sel >= 3 && sel <= 7) begin
                k[cur] = 1'b1;
            end else if (sel >= 8) begin
                a = 4'($urandom_range(0, 15));
                b = a + 4'($urandom_range(1, 15));
                k[a] = 1'b1;
                k[b] = 1'b1;
            end
            drive_frame(k, 1'($urandom_range(0, 3) != 0));
        end
        idle_frames(4);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_alternating();
        test_multi();
        test_overrun();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
